mem_arbiter: RTL and testbench

- N-channel arbiter that replaces the two-way memory mux between NockPU clients (MTU, NEM, future GC/IO units) and memory_unit.
- Selects one requesting channel, drives its func/address/write_data to memory_unit, and tracks the is_ready handshake.
- Returns registered read data and a one-cycle done pulse to the granted channel.
- Supports fixed-priority or round-robin mode, plus a per-channel lock so one client can hold the memory across back-to-back transactions (as the MTU/NEM hand-off requires).

---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// N-channel arbiter in front of memory_unit: grants one client at a time, drives its
// request to memory, and returns registered read data with a one-cycle done pulse.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module mem_arbiter #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = `MEMORY_ADDR_WIDTH,
    parameter int DATA_W  = `MEMORY_DATA_WIDTH,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_execute,
    input  logic [2*N_CH-1:0]        ch_func,
    input  logic [ADDR_W*N_CH-1:0]   ch_address,
    input  logic [DATA_W*N_CH-1:0]   ch_write_data,
    input  logic [N_CH-1:0]          ch_lock,
    output logic [N_CH-1:0]          ch_done,
    output logic [DATA_W-1:0]        ch_read_data,
    output logic [N_CH-1:0]          grant,
    output logic [2:0]               grant_idx,
    output logic                     mem_execute,
    output logic [1:0]               mem_func,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_write_data,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

    state_t             state_q, state_d;
    logic [N_CH-1:0]    grant_q, grant_d;
    logic [2:0]         grant_idx_q, grant_idx_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic               locked_q, locked_d;
    logic               fell_q, fell_d;
    logic [N_CH-1:0]    ch_done_q, ch_done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               mem_exec_q, mem_exec_d;
    logic [1:0]         mem_func_q, mem_func_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic               win_valid;
    logic [2:0]         win_idx;
    logic               lock_sel;
    int                 cand;

    // While locked only the owner may win; otherwise scan from index 0 or from rr pointer + 1.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (locked_q) begin
            for (int k = 0; k < N_CH; k++) begin
                if (k == int'(grant_idx_q) && ch_execute[k]) begin
                    win_valid = 1'b1;
                    win_idx   = grant_idx_q;
                end
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cand = (RR_MODE != 0) ? (int'(rr_ptr_q) + 1 + i) : i;
                if (cand >= N_CH) begin
                    cand = cand - N_CH;
                end
                for (int k = 0; k < N_CH; k++) begin
                    if (!win_valid && k == cand && ch_execute[k]) begin
                        win_valid = 1'b1;
                        win_idx   = 3'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        lock_sel = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (k == int'(grant_idx_q)) begin
                lock_sel = ch_lock[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        locked_d    = locked_q;
        fell_d      = fell_q;
        ch_done_d   = '0;
        rdata_d     = rdata_q;
        mem_exec_d  = 1'b0;
        mem_func_d  = mem_func_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d     = ONE_HOT0 << win_idx;
                    grant_idx_d = win_idx;
                    for (int k = 0; k < N_CH; k++) begin
                        if (k == int'(win_idx)) begin
                            mem_func_d  = ch_func[2*k +: 2];
                            mem_addr_d  = ch_address[ADDR_W*k +: ADDR_W];
                            mem_wdata_d = ch_write_data[DATA_W*k +: DATA_W];
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    mem_exec_d = 1'b1;
                    fell_d     = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completion is the rising edge of is_ready after it has been seen low.
                if (!mem_ready) begin
                    fell_d = 1'b1;
                end else if (fell_q) begin
                    rdata_d   = mem_read_data;
                    ch_done_d = grant_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_ptr_d = grant_idx_q;
                if (lock_sel) begin
                    locked_d = 1'b1;
                end else begin
                    locked_d    = 1'b0;
                    grant_d     = '0;
                    grant_idx_d = '0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= 3'(N_CH - 1);
            locked_q    <= 1'b0;
            fell_q      <= 1'b0;
            ch_done_q   <= '0;
            rdata_q     <= '0;
            mem_exec_q  <= 1'b0;
            mem_func_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            locked_q    <= locked_d;
            fell_q      <= fell_d;
            ch_done_q   <= ch_done_d;
            rdata_q     <= rdata_d;
            mem_exec_q  <= mem_exec_d;
            mem_func_q  <= mem_func_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ch_done        = ch_done_q;
    assign ch_read_data   = rdata_q;
    assign grant          = grant_q;
    assign grant_idx      = grant_idx_q;
    assign mem_execute    = mem_exec_q;
    assign mem_func       = mem_func_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-channel fixed-priority instance and a 4-channel round-robin
// instance, each attached to a small busy/ready memory model.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]      exec_a, lock_a, done_a, grant_a;
    logic [3:0]      func_a;
    logic [2*AW-1:0] addr_a;
    logic [2*DW-1:0] wdata_a;
    logic [DW-1:0]   rd_a, mem_rdata_a, mem_wdata_a;
    logic [AW-1:0]   mem_addr_a;
    logic [2:0]      gidx_a;
    logic [1:0]      mem_func_a;
    logic            mem_exec_a;
    logic            mem_ready_a = 1'b1;

    logic [3:0]      exec_b, lock_b, done_b, grant_b;
    logic [7:0]      func_b;
    logic [4*AW-1:0] addr_b;
    logic [4*DW-1:0] wdata_b;
    logic [DW-1:0]   rd_b, mem_rdata_b, mem_wdata_b;
    logic [AW-1:0]   mem_addr_b;
    logic [2:0]      gidx_b;
    logic [1:0]      mem_func_b;
    logic            mem_exec_b;
    logic            mem_ready_b = 1'b1;

    mem_arbiter #(.N_CH(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .ch_execute(exec_a), .ch_func(func_a), .ch_address(addr_a),
        .ch_write_data(wdata_a), .ch_lock(lock_a), .ch_done(done_a), .ch_read_data(rd_a),
        .grant(grant_a), .grant_idx(gidx_a), .mem_execute(mem_exec_a), .mem_func(mem_func_a),
        .mem_address(mem_addr_a), .mem_write_data(mem_wdata_a), .mem_ready(mem_ready_a),
        .mem_read_data(mem_rdata_a)
    );

    mem_arbiter #(.N_CH(4), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .ch_execute(exec_b), .ch_func(func_b), .ch_address(addr_b),
        .ch_write_data(wdata_b), .ch_lock(lock_b), .ch_done(done_b), .ch_read_data(rd_b),
        .grant(grant_b), .grant_idx(gidx_b), .mem_execute(mem_exec_b), .mem_func(mem_func_b),
        .mem_address(mem_addr_b), .mem_write_data(mem_wdata_b), .mem_ready(mem_ready_b),
        .mem_read_data(mem_rdata_b)
    );

    // Memory model: an execute pulse makes is_ready drop for lat cycles; hold forces it low.
    int lat_a = 3, cnt_a = 0, exec_cnt_a = 0;
    int cnt_b = 0, exec_cnt_b = 0;
    bit hold_a = 1'b0;

    always @(negedge clk) begin
        if (mem_exec_a) begin
            cnt_a = lat_a;
            exec_cnt_a++;
        end else if (cnt_a > 0) begin
            cnt_a--;
        end
        mem_ready_a = (cnt_a == 0) && !hold_a;
        if (mem_exec_b) begin
            cnt_b = 2;
            exec_cnt_b++;
        end else if (cnt_b > 0) begin
            cnt_b--;
        end
        mem_ready_b = (cnt_b == 0);
    end

    int done_cnt_a[2];
    bit two_hot = 1'b0;
    bit watch_lock = 1'b0;
    bit lock_broke = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done_a[i]) done_cnt_a[i]++;
        end
        if ($countones(grant_a) > 1 || $countones(grant_b) > 1 ||
            $countones(done_a) > 1 || $countones(done_b) > 1) begin
            two_hot = 1'b1;
        end
        if (watch_lock && grant_b !== 4'b0001) lock_broke = 1'b1;
    end

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitDoneA(input int budget, output logic [1:0] seen);
        bit hit;
        hit  = 1'b0;
        seen = '0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            if (done_a != 2'b00) begin
                seen = done_a;
                hit  = 1'b1;
            end
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_a: no ch_done in %0d cycles, expected a pulse", budget);
        end
    endtask

    task automatic waitDoneB(input int budget, output logic [3:0] seen);
        bit hit;
        hit  = 1'b0;
        seen = '0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            if (done_b != 4'b0000) begin
                seen = done_b;
                hit  = 1'b1;
            end
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_b: no ch_done in %0d cycles, expected a pulse", budget);
        end
    endtask

    typedef struct {
        int          ch;
        logic [1:0]  func;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [1:0]  exp_grant;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs[4];

    // One single-channel transaction on the 2-channel instance; the other channel carries decoy fields.
    task automatic applyStimulus(input vec_t v);
        int oc;
        int ec;
        logic [1:0] seen;
        oc = 1 - v.ch;
        ec = exec_cnt_a;
        func_a[2*v.ch +: 2]    = v.func;
        func_a[2*oc +: 2]      = ~v.func;
        addr_a[AW*v.ch +: AW]  = v.addr;
        addr_a[AW*oc +: AW]    = ~v.addr;
        wdata_a[DW*v.ch +: DW] = v.wdata;
        wdata_a[DW*oc +: DW]   = ~v.wdata;
        mem_rdata_a = v.rdata;
        exec_a = 2'b00;
        exec_a[v.ch] = 1'b1;
        @(negedge clk);
        checkOutput("grant_latency", grant_a, v.exp_grant);
        checkOutput("grant_idx", gidx_a, v.exp_idx);
        checkOutput("mem_func", mem_func_a, v.func);
        checkOutput("mem_address", mem_addr_a, v.addr);
        checkOutput("mem_write_data", mem_wdata_a, v.wdata);
        waitDoneA(50, seen);
        exec_a = 2'b00;
        checkOutput("ch_done", seen, v.exp_grant);
        checkOutput("ch_read_data", rd_a, v.rdata);
        @(negedge clk);
        checkOutput("done_one_cycle", done_a, 2'b00);
        checkOutput("grant_released", grant_a, 2'b00);
        checkOutput("exec_pulses", exec_cnt_a - ec, 1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] sa;
        logic [3:0] sb;
        int ec;
        int dc;
        bit saw_exec;
        int exp_order[8];

        vecs[0] = '{ch: 1, func: 2'b00, addr: 16'h0005, wdata: 16'h0000, rdata: 16'hABCD, exp_grant: 2'b10, exp_idx: 3'd1};
        vecs[1] = '{ch: 0, func: 2'b01, addr: 16'h1234, wdata: 16'hBEEF, rdata: 16'h0F0F, exp_grant: 2'b01, exp_idx: 3'd0};
        vecs[2] = '{ch: 1, func: 2'b10, addr: 16'hFFFF, wdata: 16'h5555, rdata: 16'hFFFF, exp_grant: 2'b10, exp_idx: 3'd1};
        vecs[3] = '{ch: 0, func: 2'b11, addr: 16'h0000, wdata: 16'hA5A5, rdata: 16'h0000, exp_grant: 2'b01, exp_idx: 3'd0};
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst = 1'b0;
        exec_a = '0; lock_a = '0; func_a = '0; addr_a = '0; wdata_a = '0; mem_rdata_a = '0;
        exec_b = '0; lock_b = '0; func_b = '0; addr_b = '0; wdata_b = '0; mem_rdata_b = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_grant", grant_a, 2'b00);
        checkOutput("rst_grant_idx", gidx_a, 3'd0);
        checkOutput("rst_ch_done", done_a, 2'b00);
        checkOutput("rst_read_data", rd_a, 16'h0000);
        checkOutput("rst_mem_execute", mem_exec_a, 1'b0);
        checkOutput("rst_mem_func", mem_func_a, 2'b00);
        checkOutput("rst_mem_address", mem_addr_a, 16'h0000);
        checkOutput("rst_mem_write_data", mem_wdata_a, 16'h0000);
        checkOutput("rst_grant_b", grant_b, 4'b0000);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
        end

        // Fixed priority: ch0 keeps winning while it keeps requesting.
        addr_a = 32'h0020_0010; wdata_a = 32'h0000_0000; func_a = 4'b0000;
        mem_rdata_a = 16'h1111;
        exec_a = 2'b11;
        for (int t = 0; t < 4; t++) begin
            waitDoneA(60, sa);
            if (t == 3) exec_a = 2'b10;
            checkOutput("contention_ch0", sa, 2'b01);
        end
        waitDoneA(60, sa);
        exec_a = 2'b00;
        checkOutput("contention_ch1", sa, 2'b10);
        repeat (3) @(negedge clk);

        hold_a = 1'b1;
        repeat (2) @(negedge clk);
        ec = exec_cnt_a;
        mem_rdata_a = 16'h2222;
        exec_a = 2'b01;
        saw_exec = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_exec_a) saw_exec = 1'b1;
        end
        checkOutput("busy_no_exec", saw_exec, 1'b0);
        checkOutput("busy_grant_held", grant_a, 2'b01);
        hold_a = 1'b0;
        waitDoneA(60, sa);
        exec_a = 2'b00;
        checkOutput("busy_done", sa, 2'b01);
        checkOutput("busy_read_data", rd_a, 16'h2222);
        checkOutput("busy_exec_pulses", exec_cnt_a - ec, 1);
        repeat (3) @(negedge clk);

        // Granted channel's inputs change after issue, and ch1 blips a request while ch0 is busy.
        func_a = 4'b1101; addr_a = 32'h7777_0100; wdata_a = 32'h9999_0ACE;
        mem_rdata_a = 16'h4444;
        dc = done_cnt_a[1];
        exec_a = 2'b01;
        @(negedge clk);
        func_a = 4'b1110; addr_a = 32'h7777_0200; wdata_a = 32'h9999_0BAD;
        exec_a = 2'b11;
        @(negedge clk);
        exec_a = 2'b01;
        waitDoneA(60, sa);
        exec_a = 2'b00;
        checkOutput("late_change_done", sa, 2'b01);
        checkOutput("late_change_func", mem_func_a, 2'b01);
        checkOutput("late_change_addr", mem_addr_a, 16'h0100);
        checkOutput("late_change_wdata", mem_wdata_a, 16'h0ACE);
        repeat (10) @(negedge clk);
        checkOutput("dropped_req_no_done", done_cnt_a[1] - dc, 0);
        checkOutput("dropped_req_idle", grant_a, 2'b00);

        // Reset in the middle of WAIT.
        lat_a = 6;
        func_a = 4'b0000; addr_a = 32'h0055_0000; wdata_a = 32'h0000_0000;
        mem_rdata_a = 16'h3333;
        exec_a = 2'b10;
        saw_exec = 1'b0;
        for (int c = 0; c < 20 && !saw_exec; c++) begin
            @(negedge clk);
            if (mem_exec_a) saw_exec = 1'b1;
        end
        checkOutput("rst_wait_exec_seen", saw_exec, 1'b1);
        @(negedge clk);
        dc = done_cnt_a[1];
        rst = 1'b0;
        #1;
        checkOutput("midrst_grant", grant_a, 2'b00);
        checkOutput("midrst_grant_idx", gidx_a, 3'd0);
        checkOutput("midrst_ch_done", done_a, 2'b00);
        checkOutput("midrst_read_data", rd_a, 16'h0000);
        checkOutput("midrst_mem_execute", mem_exec_a, 1'b0);
        checkOutput("midrst_mem_address", mem_addr_a, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkOutput("midrst_no_done", done_cnt_a[1] - dc, 0);
        waitDoneA(80, sa);
        exec_a = 2'b00;
        checkOutput("rearb_done", sa, 2'b10);
        checkOutput("rearb_read_data", rd_a, 16'h3333);
        lat_a = 3;
        repeat (3) @(negedge clk);

        // Round-robin across four continuously requesting channels.
        exec_b = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            waitDoneB(60, sb);
            if (t == 7) exec_b = 4'b0000;
            checkOutput("rr_order", sb, 4'b0001 << exp_order[t]);
        end
        repeat (3) @(negedge clk);

        // Lock: ch0 holds the memory for three transactions while ch1 waits.
        exec_b = 4'b0011;
        lock_b = 4'b0001;
        waitDoneB(60, sb);
        checkOutput("lock_txn1", sb, 4'b0001);
        watch_lock = 1'b1;
        waitDoneB(60, sb);
        checkOutput("lock_txn2", sb, 4'b0001);
        @(negedge clk);
        lock_b = 4'b0000;
        waitDoneB(60, sb);
        watch_lock = 1'b0;
        checkOutput("lock_txn3", sb, 4'b0001);
        waitDoneB(60, sb);
        exec_b = 4'b0000;
        checkOutput("lock_release_ch1", sb, 4'b0010);
        checkOutput("lock_grant_held", lock_broke, 1'b0);
        repeat (3) @(negedge clk);

        checkOutput("never_two_hot", two_hot, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
